display_scheduler: RTL and testbench
====================================

Name: display_scheduler

Overview:
- Time-shares the single 4-digit seven-segment display driver between up to N_REQ debug/status requesters (e.g. PC, ALU result, memory data, exception code).
- Sits between the datapath probe signals and the display driver.
- Drives the driver's number and on inputs.
- Rotates round-robin with a programmable dwell time and inserts a blank gap between sources to avoid ghosting.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DWELL_CYCLES, 1000, clk cycles each source stays shown (>=2)
- GAP_CYCLES, 4, blank cycles between sources (>=1)
- SEL_W, $clog2(N_REQ), width of sel

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req  in  N_REQ  per-requester "show me" level
- data  in  16*N_REQ  requester i value at data[16*i+15:16*i]
- hold  in  1  pauses dwell counting (user freeze button)
- number  out  16  value to display driver
- on  out  1  display enable to driver
- grant  out  N_REQ  one-hot, current owner; 0 when none
- sel  out  SEL_W  index of current/last owner

Behaviour:
- Reset values:
  - state=IDLE, on=0, number=16'h0000, grant=0, sel=N_REQ-1, cnt=0.
  - The first arbitration therefore starts searching at index 0.
- All outputs are registered; requests are sampled at the clk edge, and response appears 1 cycle later.
- Arbitration is combinational round-robin:
  - Search starts at sel+1 and wraps modulo N_REQ.
  - Picks the first i with req[i]=1.
- IDLE (on=0, grant=0, number holds):
  - If any req: go to SHOW; grant[i]=1, sel=i, on=1, cnt=0, number<=data[i] in the same edge.
  - Else stay in IDLE.
- SHOW (on=1):
  - number<=data[sel] every cycle (live value, 1-cycle latency).
  - If req[sel]=0: go to GAP next edge. This takes precedence over every other condition, including hold.
  - Else if hold=1: cnt frozen.
  - Else if cnt==DWELL_CYCLES-1:
    - Another requester pending: go to GAP.
    - No other requester: cnt<=0, stay in SHOW (same source).
  - Else cnt<=cnt+1.
- GAP (on=0, grant=0, number holds last value, sel unchanged):
  - cnt counts 0..GAP_CYCLES-1.
  - At the last count: any req goes to SHOW with the RR pick (may be the same source if it is the only one); none goes to IDLE.
  - hold is ignored in GAP.
- Wrap-around: with sel=N_REQ-1, the search begins at 0.
- Counter width is $clog2(max(DWELL_CYCLES,GAP_CYCLES)); it never exceeds its terminal value.
- A request asserted and dropped entirely inside GAP is never granted.
- Reset asserted mid-SHOW or mid-GAP immediately forces the reset values (async).

Optional Feature:
- Macro: DISPLAY_SCHEDULER_PREEMPT_EN
- Defined:
  - Requester 0 is the urgent source (e.g. exception).
  - req[0] rising while SHOW owner !=0 forces GAP on the next edge, regardless of cnt or hold.
  - Arbitration at GAP end/IDLE picks 0 whenever req[0]=1; otherwise RR.
  - While 0 owns the display, the dwell expiry does not rotate away (it acts as if there are no other requesters).
- Undefined: requester 0 is ordinary RR; no preemption logic is synthesized.

Decomposition:
- Shared package disp_pkg:
  - state enum {IDLE, SHOW, GAP}
  - DIGIT_W=16
  - BLANK_AN=4'b1111 constant for driver-related use
- One natural sub-module: rr_pick.
  - Combinational, parameter N_REQ.
  - Inputs req and last index; outputs valid and index.
  - Reused by future bus arbiters.

Test Plan (N_REQ=4, DWELL_CYCLES=8, GAP_CYCLES=2):
- Reset then req=4'b0001, data0=16'h1234:
  - One edge later on=1, grant=0001, sel=0, number=16'h1234.
  - It stays displayed indefinitely with no gaps (single requester re-arms dwell).
- req=4'b1011 held:
  - Order of ownership is 0,1,3,0,...
  - Each SHOW is 8 cycles with on=1, each separated by exactly 2 cycles of on=0, grant=0.
- Owner 1 in SHOW at cnt=3, drop req[1]:
  - Next edge state=GAP, on=0.
  - After 2 cycles the next RR requester is granted.
  - A simultaneous hold=1 does not prevent this.
- hold=1 for 20 cycles mid-SHOW with req=4'b0011: owner unchanged and on=1 throughout; rotation resumes and completes the remaining dwell after release.
- Live update: owner 2 shown, data2 changes 16'h00AA to 16'h00BB; number shows 16'h00BB exactly one cycle later.
- With DISPLAY_SCHEDULER_PREEMPT_EN and owner 3 at cnt=1, assert req[0]:
  - GAP on the next edge, then grant=0001 after 2 cycles.
  - Without the macro, owner 3 finishes 8 cycles first.

Source files
------------

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and constants for the display scheduler
package disp_pkg;

  localparam int DIGIT_W = 16;
  localparam logic [3:0] BLANK_AN = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } disp_state_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, search starts one past last
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int SEL_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             valid,
  output logic [SEL_W-1:0] index
);

  int cand;

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = (int'(last) + k) % N_REQ;
      if (req[cand[SEL_W-1:0]]) begin
        valid = 1'b1;
        index = cand[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - round-robin time-sharing of the 4-digit display driver
// Optional urgent requester 0 preemption: DISPLAY_SCHEDULER_PREEMPT_EN
module display_scheduler
  import disp_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int GAP_CYCLES   = 4,
  parameter int SEL_W        = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [DIGIT_W*N_REQ-1:0] data,
  input  logic                     hold,
  output logic [DIGIT_W-1:0]       number,
  output logic                     on,
  output logic [N_REQ-1:0]         grant,
  output logic [SEL_W-1:0]         sel
);

  localparam int CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [DIGIT_W-1:0] number_q, number_d;
  logic               on_q, on_d;

  logic               rr_valid;
  logic [SEL_W-1:0]   rr_idx;
  logic               pick_valid;
  logic [SEL_W-1:0]   pick_idx;
  logic               preempt_go;
  logic               dwell_rotate;
  logic               other_pend;
  logic [DIGIT_W-1:0] sel_data, pick_data;

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req   (req),
    .last  (sel_q),
    .valid (rr_valid),
    .index (rr_idx)
  );

  assign other_pend = |(req & ~(N_REQ'(1) << sel_q));

`ifdef DISPLAY_SCHEDULER_PREEMPT_EN
  logic req0_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) req0_q <= 1'b0;
    else        req0_q <= req[0];
  end

  // Requester 0 always wins arbitration and is never rotated away on dwell expiry.
  assign pick_valid   = rr_valid | req[0];
  assign pick_idx     = req[0] ? '0 : rr_idx;
  assign preempt_go   = req[0] & ~req0_q & (sel_q != '0);
  assign dwell_rotate = other_pend & (sel_q != '0);
`else
  assign pick_valid   = rr_valid;
  assign pick_idx     = rr_idx;
  assign preempt_go   = 1'b0;
  assign dwell_rotate = other_pend;
`endif

  always_comb begin
    sel_data  = '0;
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_q == SEL_W'(i))    sel_data  = data[i*DIGIT_W +: DIGIT_W];
      if (pick_idx == SEL_W'(i)) pick_data = data[i*DIGIT_W +: DIGIT_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    grant_d  = grant_q;
    number_d = number_q;
    on_d     = on_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d  = ST_SHOW;
          sel_d    = pick_idx;
          grant_d  = N_REQ'(1) << pick_idx;
          number_d = pick_data;
          on_d     = 1'b1;
          cnt_d    = '0;
        end
      end
      ST_SHOW: begin
        number_d = sel_data;
        // Losing the owner's request beats hold and the dwell count.
        if (!req[sel_q] || preempt_go) begin
          state_d = ST_GAP;
          on_d    = 1'b0;
          grant_d = '0;
          cnt_d   = '0;
        end else if (hold) begin
          cnt_d = cnt_q;
        end else if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (dwell_rotate) begin
            state_d = ST_GAP;
            on_d    = 1'b0;
            grant_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (pick_valid) begin
            state_d  = ST_SHOW;
            sel_d    = pick_idx;
            grant_d  = N_REQ'(1) << pick_idx;
            number_d = pick_data;
            on_d     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        on_d    = 1'b0;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sel_q    <= SEL_W'(N_REQ - 1);
      grant_q  <= '0;
      number_q <= '0;
      on_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      grant_q  <= grant_d;
      number_q <= number_d;
      on_q     <= on_d;
    end
  end

  assign number = number_q;
  assign on     = on_q;
  assign grant  = grant_q;
  assign sel    = sel_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - directed self-checking bench for display_scheduler (default build)
module tb_display_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] data;
  logic        hold;
  logic [15:0] number;
  logic        on;
  logic [3:0]  grant;
  logic [1:0]  sel;

  int tests = 0;
  int fails = 0;

  display_scheduler #(
    .N_REQ        (4),
    .DWELL_CYCLES (8),
    .GAP_CYCLES   (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .data   (data),
    .hold   (hold),
    .number (number),
    .on     (on),
    .grant  (grant),
    .sel    (sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_owner(input logic [3:0] mask, input string tag);
    for (int n = 0; n < 30 && grant !== mask; n++) step();
    check(tag, 32'(grant), 32'(mask));
  endtask

  typedef struct {
    logic [3:0] g;
    int         len;
  } seg_t;

  seg_t segs[6];

  initial begin
    reset = 1'b0;
    req   = '0;
    data  = '0;
    hold  = 1'b0;
    step();
    step();
    check("rst_on",     32'(on),     32'h0);
    check("rst_number", 32'(number), 32'h0);
    check("rst_grant",  32'(grant),  32'h0);
    check("rst_sel",    32'(sel),    32'h3);

    // single requester: shown forever, no gaps
    reset = 1'b1;
    data[15:0] = 16'h1234;
    req = 4'b0001;
    step();
    check("first_on",     32'(on),     32'h1);
    check("first_grant",  32'(grant),  32'h1);
    check("first_sel",    32'(sel),    32'h0);
    check("first_number", 32'(number), 32'h1234);
    for (int i = 0; i < 30; i++) begin
      step();
      check("single_on", 32'(on), 32'h1);
    end

    // rotation 0 -> 1 -> 3 -> 0 with 8-cycle dwell and 2-cycle gaps
    req = 4'b1011;
    for (int n = 0; n < 20 && on !== 1'b0; n++) step();
    check("rot_gap_seen", 32'(on), 32'h0);
    segs[0] = '{4'b0000, 1};
    segs[1] = '{4'b0010, 8};
    segs[2] = '{4'b0000, 2};
    segs[3] = '{4'b1000, 8};
    segs[4] = '{4'b0000, 2};
    segs[5] = '{4'b0001, 8};
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < segs[s].len; c++) begin
        step();
        check("rot_grant", 32'(grant), 32'(segs[s].g));
        check("rot_on",    32'(on),    32'(segs[s].g != 4'b0000));
      end
    end

    // drop owner 1 at cnt=3 while hold is set
    wait_owner(4'b0010, "drop_owner1");
    step();
    step();
    step();
    req  = 4'b1001;
    hold = 1'b1;
    step();
    check("drop_gap_on",    32'(on),    32'h0);
    check("drop_gap_grant", 32'(grant), 32'h0);
    check("drop_gap_sel",   32'(sel),   32'h1);
    step();
    check("drop_gap2_on", 32'(on), 32'h0);
    step();
    check("drop_next_grant", 32'(grant), 32'h8);
    check("drop_next_sel",   32'(sel),   32'h3);

    // hold for 20 cycles mid-dwell, then finish the remaining 5 cycles
    hold = 1'b0;
    req  = 4'b0011;
    wait_owner(4'b0001, "hold_owner0");
    step();
    step();
    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("hold_grant", 32'(grant), 32'h1);
      check("hold_on",    32'(on),    32'h1);
    end
    hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("resume_grant", 32'(grant), 32'h1);
    end
    step();
    check("resume_gap_on", 32'(on), 32'h0);
    step();
    check("resume_gap2_on", 32'(on), 32'h0);
    step();
    check("resume_next_grant", 32'(grant), 32'h2);

    // live data update while owner 2 is shown
    data[47:32] = 16'h00AA;
    req = 4'b0100;
    wait_owner(4'b0100, "live_owner2");
    check("live_aa", 32'(number), 32'h00AA);
    data[47:32] = 16'h00BB;
    step();
    check("live_bb", 32'(number), 32'h00BB);

    // owner 3 at cnt=1 sees req[0]: no preemption, dwell completes, wraps to 0
    req = 4'b1000;
    wait_owner(4'b1000, "pre_owner3");
    step();
    req = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      step();
      check("nopre_grant", 32'(grant), 32'h8);
    end
    step();
    check("nopre_gap_on", 32'(on), 32'h0);
    step();
    check("nopre_gap2_on", 32'(on), 32'h0);
    step();
    check("wrap_grant", 32'(grant), 32'h1);
    check("wrap_sel",   32'(sel),   32'h0);

    // all requests gone: GAP then IDLE, number holds last value
    req = 4'b0000;
    step();
    step();
    step();
    check("idle_on",     32'(on),     32'h0);
    check("idle_grant",  32'(grant),  32'h0);
    check("idle_number", 32'(number), 32'h1234);

    // request that lives only inside GAP is never granted
    req = 4'b0001;
    wait_owner(4'b0001, "gaponly_owner0");
    req = 4'b0000;
    step();
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    check("gaponly_grant", 32'(grant), 32'h0);
    step();
    check("gaponly_idle_grant", 32'(grant), 32'h0);
    check("gaponly_idle_on",    32'(on),    32'h0);

    // asynchronous reset mid-SHOW
    req = 4'b0001;
    wait_owner(4'b0001, "areset_owner0");
    #2;
    reset = 1'b0;
    #1;
    check("areset_on",     32'(on),     32'h0);
    check("areset_grant",  32'(grant),  32'h0);
    check("areset_sel",    32'(sel),    32'h3);
    check("areset_number", 32'(number), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
